// File: rtl/buf_lru_ctrl.sv
// Four-entry buffer-pool controller with LRU replacement.
// Looks up a requested tag, answers with the buffer holding it, and on a miss
// picks a victim (invalid entries first, otherwise the LRU entry) and runs a
// fill handshake with the backing store before answering.
module buf_lru_ctrl #(
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [1:0]       rsp_buf,
    output logic             rsp_hit,
    output logic             fill_req,
    output logic [1:0]       fill_buf,
    output logic [TAG_W-1:0] fill_tag,
    input  logic             fill_done,
    input  logic             inval,
    input  logic [1:0]       inval_buf,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        FILL,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0][TAG_W-1:0]   tag_q, tag_d;
    logic [3:0]              valid_q, valid_d;
    // ord_q[0] is the LRU entry, ord_q[3] the MRU entry
    logic [3:0][1:0]         ord_q, ord_d;
    logic [TAG_W-1:0]        capTag_q, capTag_d;
    logic [1:0]              fillBuf_q, fillBuf_d;
    logic [1:0]              rspBuf_q, rspBuf_d;
    logic                    rspHit_q, rspHit_d;
    logic [CNT_W-1:0]        hitCnt_q, hitCnt_d;
    logic [CNT_W-1:0]        missCnt_q, missCnt_d;

    logic                    hitAny;
    logic [1:0]              hitIdx;
    logic [1:0]              victim;

    // Remove entry e from the recency list, close the gap, append e as MRU.
    // An entry that is already MRU leaves the list unchanged.
    function automatic logic [3:0][1:0] moveToMru(input logic [3:0][1:0] ordIn,
                                                  input logic [1:0]      e);
        logic [3:0][1:0] ordOut;
        logic            found;
        ordOut = ordIn;
        found  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ordIn[i] == e) begin
                found = 1'b1;
            end
            if (found) begin
                ordOut[i] = ordIn[i+1];
            end
        end
        ordOut[3] = e;
        return ordOut;
    endfunction

    // Tag match against valid entries; tags are unique so at most one hits
    always_comb begin
        hitAny = 1'b0;
        hitIdx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (valid_q[i] && (tag_q[i] == capTag_q)) begin
                hitAny = 1'b1;
                hitIdx = 2'(i);
            end
        end
    end

    // Victim choice: lowest-index invalid entry, otherwise the LRU entry
    always_comb begin
        victim = ord_q[0];
        for (int i = 3; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim = 2'(i);
            end
        end
    end

    // Next-state and datapath updates for the lookup/fill sequence
    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        ord_d     = ord_q;
        capTag_d  = capTag_q;
        fillBuf_d = fillBuf_q;
        rspBuf_d  = rspBuf_q;
        rspHit_d  = rspHit_q;
        hitCnt_d  = hitCnt_q;
        missCnt_d = missCnt_q;

        // The entry being filled is protected from invalidation while filling
        if (inval && !((state_q == FILL) && (inval_buf == fillBuf_q))) begin
            valid_d[inval_buf] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capTag_d = req_tag;
                    state_d  = CMP;
                end
            end
            CMP: begin
                if (hitAny) begin
                    ord_d    = moveToMru(ord_q, hitIdx);
                    hitCnt_d = (hitCnt_q != '1) ? hitCnt_q + CNT_W'(1) : hitCnt_q;
                    rspBuf_d = hitIdx;
                    rspHit_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    fillBuf_d = victim;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    tag_d[fillBuf_q]   = capTag_q;
                    valid_d[fillBuf_q] = 1'b1;
                    ord_d     = moveToMru(ord_q, fillBuf_q);
                    missCnt_d = (missCnt_q != '1) ? missCnt_q + CNT_W'(1) : missCnt_q;
                    rspBuf_d  = fillBuf_q;
                    rspHit_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any open fill
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            valid_q   <= '0;
            ord_q     <= {2'd3, 2'd2, 2'd1, 2'd0};
            capTag_q  <= '0;
            fillBuf_q <= '0;
            rspBuf_q  <= '0;
            rspHit_q  <= 1'b0;
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            ord_q     <= ord_d;
            capTag_q  <= capTag_d;
            fillBuf_q <= fillBuf_d;
            rspBuf_q  <= rspBuf_d;
            rspHit_q  <= rspHit_d;
            hitCnt_q  <= hitCnt_d;
            missCnt_q <= missCnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign fill_req  = (state_q == FILL);
    assign rsp_buf   = rspBuf_q;
    assign rsp_hit   = rspHit_q;
    assign fill_buf  = fillBuf_q;
    assign fill_tag  = capTag_q;
    assign hit_cnt   = hitCnt_q;
    assign miss_cnt  = missCnt_q;

endmodule

// File: tb/tb_buf_lru_ctrl.sv
// Testbench for buf_lru_ctrl: directed scenarios plus randomized lookups,
// checked against a queue-based LRU reference model.
module tb_buf_lru_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [7:0]  req_tag;
    logic        req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_buf;
    logic        rsp_hit;
    logic        fill_req;
    logic [1:0]  fill_buf;
    logic [7:0]  fill_tag;
    logic        fill_done;
    logic        inval;
    logic [1:0]  inval_buf;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks;
    int errors;

    // Reference model: tags, valid flags, recency queue (front = LRU)
    logic [7:0] mTag [4];
    bit         mValid [4];
    int         mOrd [$];
    int         mHits;
    int         mMisses;

    buf_lru_ctrl #(.TAG_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_buf   (rsp_buf),
        .rsp_hit   (rsp_hit),
        .fill_req  (fill_req),
        .fill_buf  (fill_buf),
        .fill_tag  (fill_tag),
        .fill_done (fill_done),
        .inval     (inval),
        .inval_buf (inval_buf),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) begin
            mValid[i] = 1'b0;
            mTag[i]   = 8'h00;
        end
        mOrd    = {0, 1, 2, 3};
        mHits   = 0;
        mMisses = 0;
    endfunction

    function automatic int modelLookup(input logic [7:0] tag);
        for (int i = 0; i < 4; i++) begin
            if (mValid[i] && mTag[i] == tag) return i;
        end
        return -1;
    endfunction

    function automatic int modelVictim();
        for (int i = 0; i < 4; i++) begin
            if (!mValid[i]) return i;
        end
        return mOrd[0];
    endfunction

    function automatic void modelTouch(input int e);
        for (int i = 0; i < mOrd.size(); i++) begin
            if (mOrd[i] == e) begin
                mOrd.delete(i);
                break;
            end
        end
        mOrd.push_back(e);
    endfunction

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkOutput("rstReady", req_ready, 1);
        checkOutput("rstRsp", rsp_valid, 0);
        checkOutput("rstFill", fill_req, 0);
        checkOutput("rstFillBuf", fill_buf, 0);
        checkOutput("rstFillTag", fill_tag, 0);
        checkOutput("rstRspBuf", rsp_buf, 0);
        checkOutput("rstRspHit", rsp_hit, 0);
        checkOutput("rstHitCnt", hit_cnt, 0);
        checkOutput("rstMissCnt", miss_cnt, 0);
    endtask

    // Invalidate one entry while the controller is idle
    task automatic applyInval(input int b);
        inval     = 1'b1;
        inval_buf = 2'(b);
        @(negedge clk);
        inval     = 1'b0;
        mValid[b] = 1'b0;
        checkOutput("invalIdleReady", req_ready, 1);
    endtask

    // One lookup transaction; called at a negedge with the DUT idle.
    // delay: FILL cycles before fill_done; cmpInval: entry invalidated during
    // CMP (-1 none); fillInval: invalidate fill_buf during FILL; junk: drive
    // a stray request during FILL.
    task automatic applyStimulus(input logic [7:0] tag, input int delay, input int cmpInval,
                                 input bit fillInval, input bit junk, output int gotBuf);
        int  hitIdx;
        int  expBuf;
        bit  expHit;
        hitIdx = modelLookup(tag);
        expHit = (hitIdx >= 0);
        expBuf = expHit ? hitIdx : modelVictim();

        checkOutput("idleReady", req_ready, 1);
        req_valid = 1'b1;
        req_tag   = tag;
        @(negedge clk);
        req_valid = 1'b0;
        req_tag   = 8'($urandom);
        checkOutput("cmpReady", req_ready, 0);
        checkOutput("cmpRspValid", rsp_valid, 0);
        checkOutput("cmpFillReq", fill_req, 0);
        if (cmpInval >= 0) begin
            inval     = 1'b1;
            inval_buf = 2'(cmpInval);
        end
        @(negedge clk);
        inval = 1'b0;
        if (cmpInval >= 0) mValid[cmpInval] = 1'b0;

        if (!expHit) begin
            checkOutput("fillReq", fill_req, 1);
            checkOutput("fillBuf", fill_buf, expBuf);
            checkOutput("fillTag", fill_tag, tag);
            checkOutput("fillRspValid", rsp_valid, 0);
            if (fillInval) begin
                inval     = 1'b1;
                inval_buf = 2'(expBuf);
            end
            for (int d = 0; d < delay; d++) begin
                if (junk) begin
                    req_valid = 1'b1;
                    req_tag   = ~tag;
                end
                @(negedge clk);
                inval = 1'b0;
                checkOutput("slowFillReq", fill_req, 1);
                checkOutput("slowFillBuf", fill_buf, expBuf);
                checkOutput("slowFillTag", fill_tag, tag);
                checkOutput("slowReady", req_ready, 0);
                checkOutput("slowRspValid", rsp_valid, 0);
            end
            req_valid = 1'b0;
            fill_done = 1'b1;
            @(negedge clk);
            fill_done = 1'b0;
            inval     = 1'b0;
            mTag[expBuf]   = tag;
            mValid[expBuf] = 1'b1;
            modelTouch(expBuf);
            mMisses++;
        end else begin
            modelTouch(hitIdx);
            mHits++;
        end

        checkOutput("rspValid", rsp_valid, 1);
        checkOutput("rspBuf", rsp_buf, expBuf);
        checkOutput("rspHit", rsp_hit, expHit);
        checkOutput("rspFillReq", fill_req, 0);
        gotBuf = rsp_buf;
        @(negedge clk);
        checkOutput("postRspValid", rsp_valid, 0);
        checkOutput("postReady", req_ready, 1);
        checkOutput("hitCnt", hit_cnt, mHits);
        checkOutput("missCnt", miss_cnt, mMisses);
    endtask

    task automatic coldFill();
        int b;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h10 + 8'(i), 1, -1, 1'b0, 1'b0, b);
            checkOutput("coldVictim", b, i);
        end
        checkOutput("coldMissCnt", miss_cnt, 4);
    endtask

    initial begin
        int b;
        int lruExp [4];
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_tag   = 8'h00;
        fill_done = 1'b0;
        inval     = 1'b0;
        inval_buf = 2'd0;
        modelReset();

        // Cold fill, hit latency, replacement of LRU
        applyReset();
        coldFill();
        applyStimulus(8'h11, 0, -1, 1'b0, 1'b0, b);
        checkOutput("hitBuf", b, 1);
        applyStimulus(8'h20, 0, -1, 1'b0, 1'b0, b);
        checkOutput("replVictim", b, 0);

        // LRU order after a permuted hit sequence
        applyReset();
        coldFill();
        applyStimulus(8'h11, 0, -1, 1'b0, 1'b0, b);
        applyStimulus(8'h10, 0, -1, 1'b0, 1'b0, b);
        applyStimulus(8'h13, 0, -1, 1'b0, 1'b0, b);
        applyStimulus(8'h12, 0, -1, 1'b0, 1'b0, b);
        lruExp = '{1, 0, 3, 2};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h30 + 8'(i), 0, -1, 1'b0, 1'b0, b);
            checkOutput("lruVictim", b, lruExp[i]);
        end
        applyStimulus(8'h31, 0, -1, 1'b0, 1'b0, b);
        checkOutput("lruHitBuf", b, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h40 + 8'(i), 0, -1, 1'b0, 1'b0, b);
        end

        // Invalid entries are chosen before the LRU entry
        applyReset();
        coldFill();
        applyInval(2);
        applyStimulus(8'h50, 0, -1, 1'b0, 1'b0, b);
        checkOutput("invalVictim", b, 2);
        applyStimulus(8'h12, 0, -1, 1'b0, 1'b0, b);
        checkOutput("oldTagVictim", b, 0);
        applyStimulus(8'h60, 1, -1, 1'b1, 1'b0, b);
        applyStimulus(8'h60, 0, -1, 1'b0, 1'b0, b);
        checkOutput("fillInvalKeptHit", rsp_hit, 1);

        // Slow fill with stray requests, then a stray fill_done while idle
        applyStimulus(8'h70, 20, -1, 1'b0, 1'b1, b);
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        checkOutput("idleDoneRsp", rsp_valid, 0);
        checkOutput("idleDoneReady", req_ready, 1);
        checkOutput("idleDoneMiss", miss_cnt, mMisses);

        // Reset in the middle of a fill abandons it
        applyReset();
        applyStimulus(8'h80, 0, -1, 1'b0, 1'b0, b);
        req_valid = 1'b1;
        req_tag   = 8'h81;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("midFillReq", fill_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkOutput("midRstFill", fill_req, 0);
        checkOutput("midRstReady", req_ready, 1);
        checkOutput("midRstRsp", rsp_valid, 0);
        checkOutput("midRstMiss", miss_cnt, 0);
        checkOutput("midRstHit", hit_cnt, 0);
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        checkOutput("lateDoneRsp", rsp_valid, 0);
        checkOutput("lateDoneMiss", miss_cnt, 0);
        applyStimulus(8'h80, 0, -1, 1'b0, 1'b0, b);
        checkOutput("postRstVictim", b, 0);
        checkOutput("postRstHit", rsp_hit, 0);

        // Randomized traffic over a small tag pool
        for (int n = 0; n < 150; n++) begin
            int cInv;
            if ($urandom_range(0, 9) == 0) applyInval(int'($urandom_range(0, 3)));
            cInv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            applyStimulus(8'h90 + 8'($urandom_range(0, 6)), int'($urandom_range(0, 3)), cInv,
                          ($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)), b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
